fetch_sequencer: RTL and testbench

//  Program counter and fetch controller that drives the instruction ROM address bus.

---
 rtl/fetch_sequencer.sv | 127 ++++++++++++
 tb/tb_fetch_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Program counter and fetch controller that drives the instruction ROM.
//   A program starts on request at start_addr. The PC then advances by one
//   per committed instruction, or is redirected by a relative or absolute
//   branch. A halt ends the run with a one-cycle done pulse. inst_count
//   reports how many instructions have committed since the last accepted
//   start, and it saturates at its maximum value.
//
// Ports
//   clk           in   1   clock, rising edge
//   rst           in   1   asynchronous, active-high reset
//   start         in   1   begin a program at start_addr (honoured in IDLE only)
//   start_addr    in   A   first instruction address
//   stall         in   1   hold the current instruction; nothing commits
//   halt          in   1   current instruction is a halt
//   branch_en     in   1   current instruction redirects the PC
//   branch_rel    in   1   1: PC + branch_ofs, 0: absolute target
//   branch_ofs    in   A   two's-complement relative offset
//   target        in   A   absolute branch/jump target
//   inst_in       in   W   ROM data for inst_address (combinational ROM)
//   inst_address  out  A   PC to ROM
//   inst          out  W   inst_in forwarded to decode, zero when not valid
//   inst_valid    out  1   current instruction commits this cycle
//   busy          out  1   sequencer is in RUN
//   done          out  1   one-cycle pulse after the halt commits
//   inst_count    out  CW  instructions committed since the last accepted start
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int A  = 12,
  parameter int W  = 10,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [A-1:0]  start_addr,
  input  logic          stall,
  input  logic          halt,
  input  logic          branch_en,
  input  logic          branch_rel,
  input  logic [A-1:0]  branch_ofs,
  input  logic [A-1:0]  target,
  input  logic [W-1:0]  inst_in,
  output logic [A-1:0]  inst_address,
  output logic [W-1:0]  inst,
  output logic          inst_valid,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] inst_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [A-1:0]  pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  // NOTE: every signal driven here gets a default before the case statement.
  // This keeps each path fully assigned, so no latch can be inferred.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    inst_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = start_addr;
          count_d = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        busy       = 1'b1;
        inst_valid = !stall;
        // A stalled cycle commits nothing, so halt and branch_en are ignored.
        if (!stall) begin
          if (count_q != '1) count_d = count_q + 1'b1;
          // Halt outranks a branch: the PC stays on the halt instruction.
          if (halt) begin
            state_d = S_DONE;
          end else if (branch_en) begin
            // An A-bit add wraps modulo 2**A, which also covers negative offsets.
            pc_d = branch_rel ? pc_q + branch_ofs : target;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign inst_address = pc_q;
  assign inst_count   = count_q;
  assign inst         = inst_valid ? inst_in : '0;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Self-checking bench for fetch_sequencer. It runs directed scenarios with
//   constant expectations, then applies random stimulus that is compared
//   every cycle against a cycle-level behavioural model of the PC, the
//   commit count and the run phase.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  localparam int A    = 12;
  localparam int W    = 10;
  localparam int CW   = 16;
  localparam int AMOD = 1 << A;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [A-1:0]  start_addr;
  logic          stall;
  logic          halt;
  logic          branch_en;
  logic          branch_rel;
  logic [A-1:0]  branch_ofs;
  logic [A-1:0]  target;
  logic [W-1:0]  inst_in;
  logic [A-1:0]  inst_address;
  logic [W-1:0]  inst;
  logic          inst_valid;
  logic          busy;
  logic          done;
  logic [CW-1:0] inst_count;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = idle, 1 = running, 2 = done pulse.
  int m_phase = 0;
  int m_pc    = 0;
  int m_count = 0;

  fetch_sequencer #(.A(A), .W(W), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .start_addr   (start_addr),
    .stall        (stall),
    .halt         (halt),
    .branch_en    (branch_en),
    .branch_rel   (branch_rel),
    .branch_ofs   (branch_ofs),
    .target       (target),
    .inst_in      (inst_in),
    .inst_address (inst_address),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .busy         (busy),
    .done         (done),
    .inst_count   (inst_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = 0;
    m_pc    = 0;
    m_count = 0;
  endtask

  // Applies one rising edge worth of behaviour to the model using current inputs.
  task automatic model_step();
    case (m_phase)
      0: if (start) begin
        m_pc    = int'(start_addr);
        m_count = 0;
        m_phase = 1;
      end
      1: if (!stall) begin
        m_count = (m_count < CMAX) ? m_count + 1 : CMAX;
        if (halt)           m_phase = 2;
        else if (branch_en) m_pc = branch_rel ? (m_pc + int'(branch_ofs)) % AMOD : int'(target);
        else                m_pc = (m_pc + 1) % AMOD;
      end
      default: m_phase = 0;
    endcase
  endtask

  // Advances one clock: model first (inputs as seen at the edge), then the DUT.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    start      = 1'b0;
    stall      = 1'b0;
    halt       = 1'b0;
    branch_en  = 1'b0;
    branch_rel = 1'b0;
    branch_ofs = '0;
    target     = '0;
    inst_in    = W'($urandom);
  endtask

  // Starts a program at addr and returns in the first RUN cycle.
  task automatic launch(input logic [A-1:0] addr);
    quiet_inputs();
    start_addr = addr;
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Commits a halt in the current RUN cycle and returns back in IDLE.
  task automatic finish_program();
    quiet_inputs();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    quiet_inputs();
    start_addr = '0;
    #12;
    checks++; if (inst_address !== 12'h000) begin errors++; $display("FAIL reset_addr: got %h expected 000", inst_address); end
    checks++; if ({busy, inst_valid, done} !== 3'b000) begin errors++; $display("FAIL reset_flags: busy/valid/done got %b expected 000", {busy, inst_valid, done}); end
    checks++; if (inst_count !== 16'h0000) begin errors++; $display("FAIL reset_count: got %h expected 0000", inst_count); end
    checks++; if (inst !== 10'h000) begin errors++; $display("FAIL reset_inst: got %h expected 000", inst); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_linear();
    launch(12'h010);
    for (int i = 0; i < 5; i++) begin
      halt    = (i == 4);
      inst_in = W'($urandom);
      #1;
      checks++; if (inst_address !== 12'(12'h010 + i)) begin errors++; $display("FAIL linear_addr[%0d]: got %h expected %h", i, inst_address, 12'h010 + i); end
      checks++; if ({busy, inst_valid, done} !== 3'b110) begin errors++; $display("FAIL linear_flags[%0d]: got %b expected 110", i, {busy, inst_valid, done}); end
      checks++; if (inst !== inst_in) begin errors++; $display("FAIL linear_inst[%0d]: got %h expected %h", i, inst, inst_in); end
      tick();
    end
    halt = 1'b0;
    checks++; if ({busy, inst_valid, done} !== 3'b001) begin errors++; $display("FAIL linear_done: got %b expected 001", {busy, inst_valid, done}); end
    checks++; if (inst_count !== 16'd5) begin errors++; $display("FAIL linear_count: got %0d expected 5", inst_count); end
    checks++; if (inst !== 10'h000) begin errors++; $display("FAIL linear_inst_zero: got %h expected 000", inst); end
    tick();
    checks++; if ({busy, done, inst_count} !== {2'b00, 16'd5}) begin errors++; $display("FAIL linear_idle: busy/done/count got %b/%b/%0d expected 0/0/5", busy, done, inst_count); end
  endtask

  task automatic test_branch();
    launch(12'h020);
    branch_en  = 1'b1;
    branch_rel = 1'b1;
    branch_ofs = 12'hFFC;
    tick();
    checks++; if (inst_address !== 12'h01C) begin errors++; $display("FAIL branch_rel: got %h expected 01c", inst_address); end
    branch_rel = 1'b0;
    target     = 12'h300;
    tick();
    checks++; if (inst_address !== 12'h300) begin errors++; $display("FAIL branch_abs: got %h expected 300", inst_address); end
    checks++; if (inst_count !== 16'd2) begin errors++; $display("FAIL branch_count: got %0d expected 2", inst_count); end
    finish_program();
  endtask

  task automatic test_stall();
    launch(12'h005);
    stall     = 1'b1;
    halt      = 1'b1;
    branch_en = 1'b1;
    target    = 12'h3AB;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({inst_address, inst_valid, busy, inst} !== {12'h005, 2'b01, 10'h000}) begin errors++; $display("FAIL stall_hold[%0d]: addr/valid/busy/inst got %h/%b/%b/%h expected 005/0/1/000", i, inst_address, inst_valid, busy, inst); end
      checks++; if (inst_count !== 16'd0) begin errors++; $display("FAIL stall_count[%0d]: got %0d expected 0", i, inst_count); end
      tick();
    end
    stall = 1'b0;
    #1;
    checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL stall_release: valid got %b expected 1", inst_valid); end
    tick();
    quiet_inputs();
    checks++; if ({done, inst_address, inst_count} !== {1'b1, 12'h005, 16'd1}) begin errors++; $display("FAIL stall_done: done/addr/count got %b/%h/%0d expected 1/005/1", done, inst_address, inst_count); end
    tick();
  endtask

  task automatic test_wrap();
    launch(12'hFFE);
    for (int i = 0; i < 3; i++) begin
      start      = (i == 1);
      start_addr = 12'h555;
      #1;
      checks++; if (inst_address !== 12'((12'hFFE + i) % AMOD)) begin errors++; $display("FAIL wrap_addr[%0d]: got %h expected %h", i, inst_address, 12'((12'hFFE + i) % AMOD)); end
      tick();
    end
    start = 1'b0;
    checks++; if ({inst_address, inst_count} !== {12'h001, 16'd3}) begin errors++; $display("FAIL wrap_after: addr/count got %h/%0d expected 001/3", inst_address, inst_count); end
    finish_program();
  endtask

  task automatic test_halt_priority();
    launch(12'h040);
    halt       = 1'b1;
    branch_en  = 1'b1;
    target     = 12'h123;
    start      = 1'b1;
    start_addr = 12'h077;
    tick();
    halt      = 1'b0;
    branch_en = 1'b0;
    checks++; if ({done, busy, inst_address} !== {2'b10, 12'h040}) begin errors++; $display("FAIL prio_done: done/busy/addr got %b/%b/%h expected 1/0/040", done, busy, inst_address); end
    tick();
    checks++; if ({done, busy, inst_address} !== {2'b00, 12'h040}) begin errors++; $display("FAIL prio_idle: done/busy/addr got %b/%b/%h expected 0/0/040", done, busy, inst_address); end
    tick();
    start = 1'b0;
    checks++; if ({busy, inst_address, inst_count} !== {1'b1, 12'h077, 16'd0}) begin errors++; $display("FAIL prio_restart: busy/addr/count got %b/%h/%0d expected 1/077/0", busy, inst_address, inst_count); end
    finish_program();
  endtask

  task automatic test_random();
    logic exp_valid;
    for (int i = 0; i < 600; i++) begin
      start      = ($urandom_range(2) == 0);
      start_addr = A'($urandom);
      stall      = ($urandom_range(3) == 0);
      halt       = ($urandom_range(9) == 0);
      branch_en  = ($urandom_range(3) == 0);
      branch_rel = $urandom_range(1) == 1;
      branch_ofs = A'($urandom);
      target     = A'($urandom);
      inst_in    = W'($urandom);
      #1;
      exp_valid = (m_phase == 1) && !stall;
      checks++; if (inst_address !== A'(m_pc)) begin errors++; $display("FAIL rand_addr[%0d]: got %h expected %h", i, inst_address, A'(m_pc)); end
      checks++; if ({busy, done, inst_valid} !== {m_phase == 1, m_phase == 2, exp_valid}) begin errors++; $display("FAIL rand_flags[%0d]: busy/done/valid got %b expected %b", i, {busy, done, inst_valid}, {m_phase == 1, m_phase == 2, exp_valid}); end
      checks++; if (inst_count !== CW'(m_count)) begin errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", i, inst_count, m_count); end
      checks++; if (inst !== (exp_valid ? inst_in : W'(0))) begin errors++; $display("FAIL rand_inst[%0d]: got %h expected %h", i, inst, exp_valid ? inst_in : W'(0)); end
      tick();
    end
    quiet_inputs();
  endtask

  task automatic test_reset_mid_run();
    // Return to a known idle state regardless of where the random run ended.
    #2 rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    launch(12'h09E);
    tick();
    tick();
    checks++; if ({busy, inst_address} !== {1'b1, 12'h0A0}) begin errors++; $display("FAIL midrst_pre: busy/addr got %b/%h expected 1/0a0", busy, inst_address); end
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++; if ({inst_address, busy, inst_valid, done, inst_count} !== {12'h000, 3'b000, 16'd0}) begin errors++; $display("FAIL midrst_now: addr/busy/valid/done/count got %h/%b/%b/%b/%0d expected 000/0/0/0/0", inst_address, busy, inst_valid, done, inst_count); end
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_nodone: got %b expected 0", done); end
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL midrst_after: done/busy got %b expected 00", {done, busy}); end
  endtask

  task automatic test_saturation();
    launch(A'($urandom));
    for (int k = 1; k <= CMAX + 2; k++) begin
      tick();
      if (k == CMAX - 1) begin
        checks++; if (inst_count !== 16'hFFFE) begin errors++; $display("FAIL sat_below: got %h expected fffe", inst_count); end
      end
      if (k == CMAX) begin
        checks++; if (inst_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h expected ffff", inst_count); end
      end
    end
    checks++; if (inst_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffff", inst_count); end
    finish_program();
    checks++; if (inst_count !== 16'hFFFF) begin errors++; $display("FAIL sat_idle: got %h expected ffff", inst_count); end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_branch();
    test_stall();
    test_wrap();
    test_halt_priority();
    test_random();
    test_reset_mid_run();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Done, busy and inst_valid must never be asserted together.
  always @(negedge clk) begin
    if (!rst && (busy && done)) begin
      errors++;
      $display("FAIL exclusive_flags: busy/done/valid got %b%b%b expected at most one phase", busy, done, inst_valid);
    end
  end

endmodule
